// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial transmit/receive pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: tx_state_t frame FSM encoding, line constants for idle/start/stop.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts clocks within a bit and flags the last clock of each period.
// Latency: bit_tick is high on clock CLKS_PER_BIT-1 after restart is released.
// Backpressure: none; free-running while restart is low.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   restart  holds the counter at zero (used while the line is idle)
//   bit_tick high during the final clock of every bit period
module serial_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

   logic [CNT_W-1:0] cnt_q;

   assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // Wraps to zero on the tick, so every state or bit change starts a fresh period.
   always_ff @(posedge clk) begin
      if (rst || restart || bit_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Latency: start bit appears on tx_o the cycle after the valid/ready handshake.
// Backpressure: ready_o high only while idle; valid_i during a frame is ignored, nothing is buffered.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   data_i     byte latched on handshake;  valid_i  data_i is valid
//   ready_o    idle and able to accept a byte
//   tx_o       serial line (idles high);   busy_o   frame in progress
//   done_o     one-cycle pulse in the first idle cycle after a frame
// Build option: define SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              bit_tick;
   logic              xfer;
   logic              last_bit;
   logic              tx_d, ready_d, busy_d, done_d;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q;
`endif

   // ready_o is registered and mirrors state_q == IDLE, so it is safe to use here.
   assign xfer     = valid_i && ready_o;
   assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));

   serial_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .restart  (state_q == IDLE),
      .bit_tick (bit_tick)
   );

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tx_o      <= LINE_IDLE;
         ready_o   <= 1'b1;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tx_o      <= tx_d;
         ready_o   <= ready_d;
         busy_o    <= busy_d;
         done_o    <= done_d;
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (xfer) begin
         parity_q <= ^data_i;
      end
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d   = START;
               shreg_d   = data_i;
               bit_cnt_d = '0;
            end
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               shreg_d = shreg_q >> 1;
               if (last_bit) begin
                  bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: computed from the next state so the registered outputs line up with it.
   always_comb begin
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_q == STOP) && (state_d == IDLE);
      tx_d    = LINE_IDLE;
      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         STOP:    tx_d = STOP_BIT;
         default: tx_d = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: scoreboarded frames checked cycle by cycle on tx_o/busy_o/done_o.
module tb_serial_tx;

   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CLKS = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_i = 8'h00;
   logic       valid_i = 1'b0;
   logic       ready_o, tx_o, busy_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   serial_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .tx_o    (tx_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected line pattern, index 0 = start bit.
   function automatic logic [15:0] build_frame(input logic [7:0] d);
      logic [15:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
      b[9] = ^d;
`endif
      b[FRAME_BITS-1] = 1'b1;
      return b;
   endfunction

   logic [15:0] exp_q[$];
   int          starts[$];
   logic [15:0] cur_bits;
   int          mon_cyc = -1;
   int          cyc = 0;
   int          done_cnt = 0;
   logic        done_pending = 1'b0;
   logic        hs_pending = 1'b0;
   logic        rst_q = 1'b1;

   always @(posedge clk) rst_q <= rst;

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (done_o) done_cnt++;
      if (rst_q) begin
         check_eq("reset_outputs", {28'd0, tx_o, ready_o, busy_o, done_o}, 32'b1100);
         mon_cyc      = -1;
         done_pending = 1'b0;
         hs_pending   = 1'b0;
      end else begin
         if (mon_cyc < 0) begin
            if (hs_pending) begin
               check_eq("start_latency", {31'd0, busy_o}, 32'd1);
               cur_bits = exp_q.pop_front();
               mon_cyc  = 0;
               starts.push_back(cyc);
            end else if (busy_o) begin
               check_eq("spurious_frame", {31'd0, busy_o}, 32'd0);
            end else if (done_pending) begin
               check_eq("done_cycle", {28'd0, tx_o, ready_o, busy_o, done_o}, 32'b1101);
               done_pending = 1'b0;
            end else begin
               check_eq("idle_line", {28'd0, tx_o, ready_o, busy_o, done_o}, 32'b1100);
            end
         end
         if (mon_cyc >= 0) begin
            check_eq("frame_line", {29'd0, tx_o, busy_o, done_o},
                     {29'd0, cur_bits[mon_cyc / CPB], 1'b1, 1'b0});
            mon_cyc++;
            if (mon_cyc == FRAME_CLKS) begin
               mon_cyc      = -1;
               done_pending = 1'b1;
            end
         end
         hs_pending = 1'b0;
      end
      // Inputs are stable here; a handshake will occur at the coming posedge.
      if (!rst && valid_i && ready_o) begin
         exp_q.push_back(build_frame(data_i));
         hs_pending = 1'b1;
      end
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq(tag, {31'd0, ready_o}, 32'd1);
   endtask

   task automatic send(input logic [7:0] d);
      wait_ready("send_ready");
      valid_i = 1'b1;
      data_i  = d;
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      int s0;

      // Reset hold with a pending request that must not start a frame.
      rst     = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      valid_i = 1'b0;
      idle_cycles(3);

      // Single frames.
      d0 = done_cnt;
      send(8'hA5);
      idle_cycles(FRAME_CLKS + 5);
      check_eq("done_count_a5", done_cnt, d0 + 1);
      send(8'h07);
      idle_cycles(FRAME_CLKS + 5);

      // Back-to-back with valid held high.
      d0 = done_cnt;
      s0 = starts.size();
      wait_ready("b2b_ready1");
      valid_i = 1'b1;
      data_i  = 8'h3C;
      @(posedge clk); #1;
      data_i  = 8'hC3;
      wait_ready("b2b_ready2");
      @(posedge clk); #1;
      valid_i = 1'b0;
      idle_cycles(FRAME_CLKS + 5);
      check_eq("b2b_done_count", done_cnt, d0 + 2);
      check_eq("b2b_frames", starts.size(), s0 + 2);
      if (starts.size() >= s0 + 2)
         check_eq("b2b_gap", starts[s0+1] - starts[s0], FRAME_CLKS + 1);

      // Request while busy is dropped.
      d0 = done_cnt;
      send(8'hFF);
      idle_cycles(15);
      valid_i = 1'b1;
      data_i  = 8'h00;
      @(posedge clk); #1;
      valid_i = 1'b0;
      idle_cycles(FRAME_CLKS + 10);
      check_eq("ignored_done_count", done_cnt, d0 + 1);

      // Reset during data bit 3, then a clean frame.
      d0 = done_cnt;
      send(8'h96);
      idle_cycles(17);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midreset_tx", {31'd0, tx_o}, 32'd1);
      check_eq("midreset_ready", {31'd0, ready_o}, 32'd1);
      idle_cycles(FRAME_CLKS);
      check_eq("midreset_no_done", done_cnt, d0);
      send(8'h5A);
      idle_cycles(FRAME_CLKS + 5);
      check_eq("done_count_5a", done_cnt, d0 + 1);

      check_eq("scoreboard_drain", exp_q.size(), 0);
      check_eq("monitor_idle", mon_cyc, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out frame transmitter. It is the transmit-side counterpart of the shift-register serial receive path.
- Accepts one byte through a valid/ready handshake and shifts it out on one line as a frame: start bit, data bits LSB first, optional parity bit, stop bit.
- Each bit is held for a programmable number of clocks.
- Sits between the parallel datapath and an off-block serial pin.

Parameters:
- DATA_W, 8: data bits per frame.
- CLKS_PER_BIT, 4: clocks each bit is held on tx_o. Minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data_i  input  DATA_W  byte to transmit, sampled on handshake
- valid_i  input  1  data_i is valid
- ready_o  output  1  block can accept a byte (high only in IDLE)
- tx_o  output  1  serial line, idles high
- busy_o  output  1  a frame is in progress (any state except IDLE)
- done_o  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst high at a posedge) takes priority over everything, including mid-frame.
  - state = IDLE, tx_o = 1, ready_o = 1, busy_o = 0, done_o = 0.
  - Bit counter, clock counter and shift register = 0.
  - A partially sent frame is abandoned; the line returns high on the next cycle.
- Handshake: a transfer occurs when valid_i && ready_o at a posedge.
  - data_i is latched into the internal shift register.
  - The FSM enters START on the next cycle.
  - valid_i while busy is ignored; no buffering.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
  - IDLE: tx_o = 1. Transfer -> START.
  - START: tx_o = 0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_o = shreg[0] for CLKS_PER_BIT cycles per bit.
    - At the end of each bit period: shreg shifts right one place (zero fill) and the bit counter increments.
    - After DATA_W bits -> PARITY if enabled, else STOP.
  - PARITY: tx_o = parity bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_o = 1 for CLKS_PER_BIT cycles -> IDLE.
- Clock counter:
  - Width $clog2(CLKS_PER_BIT) + 1. Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit transition.
  - CLKS_PER_BIT = 1 means one cycle per bit.
- done_o is asserted for exactly one cycle: the first IDLE cycle after STOP ends. ready_o is also high in that cycle.
- Back-to-back frames: a handshake in that same done_o cycle is legal.
  - Next start bit follows immediately.
  - Minimum gap between frames: one idle-high cycle.
- Frame latency: handshake edge to first start-bit cycle = 1 clock.
- Frame length: (DATA_W + 2 [+1 with parity]) × CLKS_PER_BIT clocks.
- tx_o, ready_o, busy_o and done_o are all registered outputs (no combinational path from inputs).

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN
- Defined:
  - The PARITY state exists.
  - Parity bit = XOR of the latched data byte (even parity), computed at handshake and held in a register.
  - Frame is DATA_W + 3 bits.
- Undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP; frame is DATA_W + 2 bits.

Decomposition:
- Package serial_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}, 3-bit encoding.
  - Constants: LINE_IDLE = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1.
  - The same package is reused by a future matching receiver.
- One natural sub-module, serial_bit_timer: clock counter producing a one-cycle bit_tick at the end of each bit period, with a synchronous restart input.
- FSM, shift register and bit counter stay in serial_tx.

Test Plan (CLKS_PER_BIT = 4, DATA_W = 8):
- Reset hold:
  - rst = 1 for 3 cycles with valid_i = 1, data_i = 0xFF -> tx_o = 1, ready_o = 1, busy_o = 0, done_o = 0 throughout; no frame starts.
- Single frame, parity off:
  - Send 0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 clocks total).
  - busy_o high for all 40 clocks; done_o pulses once on clock 41.
- Parity on (SERIAL_TX_PARITY_EN):
  - Send 0xA5 -> parity bit 0 after data, 44 clocks.
  - Send 0x07 -> parity bit 1.
- Back-to-back:
  - Hold valid_i high with 0x3C, then 0xC3 -> second start bit begins exactly 1 clock after the first STOP ends.
  - Exactly one idle-high cycle between frames; done_o pulses twice.
- Ignored input while busy:
  - Pulse valid_i with 0x00 mid-DATA of a 0xFF frame -> the frame still transmits 0xFF; no extra frame follows.
- Reset mid-frame:
  - Assert rst during data bit 3 -> next cycle tx_o = 1, state IDLE, ready_o = 1, no done_o pulse.
  - A subsequent 0x5A frame transmits correctly.
